// File: rtl/padbid_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// padbid_ctrl_pkg
// Shared definitions for the PADBID direction controller:
//   - default parameter constants
//   - controller state enumeration
//   - phase counter width helper
// No ports (package).
// -----------------------------------------------------------------------------
package padbid_ctrl_pkg;

    localparam int DEF_WIDTH       = 5;
    localparam int DEF_TURN_CYCLES = 2;
    localparam int DEF_HOLD_CYCLES = 3;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TURN_TX = 2'd1,
        DRIVE   = 2'd2,
        TURN_RX = 2'd3
    } state_e;

    // Width needed to hold (longest phase - 1); never narrower than 1 bit.
    function automatic int cnt_width(input int turn_rx_len, input int hold_len);
        int longest;
        longest = (turn_rx_len > hold_len) ? turn_rx_len : hold_len;
        return (longest <= 1) ? 1 : $clog2(longest);
    endfunction

endpackage

// File: rtl/padbid_dir_ctrl_if.sv
// -----------------------------------------------------------------------------
// padbid_dir_ctrl_if
// Bundles the core-side transmit/receive handshake and the pad-side PADBID
// signals of the direction controller.
//   tx_valid/tx_ready/tx_data : core transmit request
//   rx_valid/rx_data          : synchronised receive change report
//   busy                      : controller not idle
//   pad_i/pad_oen/pad_c       : PADBID .I / .OEN (0=drive) / .C
//   lb_err/lb_err_clr         : sticky loopback error and its clear
// Modports: slave = controller side, master = core/pad environment side.
// -----------------------------------------------------------------------------
interface padbid_dir_ctrl_if
    import padbid_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] tx_data;
    logic             rx_valid;
    logic [WIDTH-1:0] rx_data;
    logic             busy;
    logic [WIDTH-1:0] pad_i;
    logic [WIDTH-1:0] pad_oen;
    logic [WIDTH-1:0] pad_c;
    logic             lb_err;
    logic             lb_err_clr;

    modport slave (
        input  tx_valid, tx_data, pad_c, lb_err_clr,
        output tx_ready, rx_valid, rx_data, busy, pad_i, pad_oen, lb_err
    );

    modport master (
        output tx_valid, tx_data, pad_c, lb_err_clr,
        input  tx_ready, rx_valid, rx_data, busy, pad_i, pad_oen, lb_err
    );

endinterface

// File: rtl/padbid_sync.sv
// -----------------------------------------------------------------------------
// padbid_sync
// WIDTH-wide, SYNC_STAGES-deep flop synchroniser for the pad C inputs.
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous reset, active-high; clears every stage to 0
//   i_d  in   asynchronous pad values
//   o_q  out  synchronised values (last stage)
// -----------------------------------------------------------------------------
module padbid_sync
    import padbid_ctrl_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: this array is a chain of discrete flops, not a RAM, so
            // clearing every entry on reset is intended and cheap.
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let every stage sample its
            // predecessor's old value, giving a true shift rather than a
            // single flop.
            r_stage[0] <= i_d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/padbid_dir_ctrl.sv
// -----------------------------------------------------------------------------
// padbid_dir_ctrl
// Core-side direction controller for a bank of WIDTH PADBID pads. Sequences
// IDLE -> TURN_TX -> DRIVE -> TURN_RX -> IDLE around each transmit, keeping
// OEN high for guard cycles on both sides of the drive window, and reports
// changes of the synchronised pad value while idle.
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous reset, active-high
//   bus  slave modport of padbid_dir_ctrl_if (tx/rx handshake, pad signals,
//        loopback error)
// Configuration macro: PADBID_LOOPBACK_CHK_EN
//   defined   - compares the echoed pad value with the transmitted data in
//               the last driven cycle and raises sticky lb_err on mismatch
//   undefined - lb_err is tied 0 and lb_err_clr is ignored
// -----------------------------------------------------------------------------
module padbid_dir_ctrl
    import padbid_ctrl_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int TURN_CYCLES = DEF_TURN_CYCLES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst,
    padbid_dir_ctrl_if.slave  bus
);

    localparam int TURN_RX_LEN = TURN_CYCLES + SYNC_STAGES;
    localparam int CW          = cnt_width(TURN_RX_LEN, HOLD_CYCLES);

    localparam logic [CW-1:0] TURN_TX_LOAD = CW'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);
    localparam logic [CW-1:0] HOLD_LOAD    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TURN_RX_LOAD = CW'(TURN_RX_LEN - 1);

    if (HOLD_CYCLES < 1 || SYNC_STAGES < 2 || TURN_CYCLES < 0) begin : g_bad_params
        $error("padbid_dir_ctrl: need HOLD_CYCLES>=1, SYNC_STAGES>=2, TURN_CYCLES>=0");
    end

    state_e           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_baseline;
    logic             r_tx_ready;
    logic             r_busy;
    logic [WIDTH-1:0] r_pad_i;
    logic [WIDTH-1:0] r_pad_oen;
    logic             r_rx_valid;
    logic [WIDTH-1:0] r_rx_data;

    logic [WIDTH-1:0] w_sync;
    logic             w_accept;
    logic             w_phase_done;

    padbid_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (bus.pad_c),
        .o_q (w_sync)
    );

    assign w_accept     = (r_state == IDLE) && bus.tx_valid && r_tx_ready;
    assign w_phase_done = (r_cnt == '0);

    // Phase sequencing: the counter is loaded with (phase length - 1) on
    // every state entry and counts down to zero, so it never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_data <= bus.tx_data;
                        if (TURN_CYCLES == 0) begin
                            r_state <= DRIVE;
                            r_cnt   <= HOLD_LOAD;
                        end else begin
                            r_state <= TURN_TX;
                            r_cnt   <= TURN_TX_LOAD;
                        end
                    end
                end
                TURN_TX: begin
                    if (w_phase_done) begin
                        r_state <= DRIVE;
                        r_cnt   <= HOLD_LOAD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DRIVE: begin
                    if (w_phase_done) begin
                        r_state <= TURN_RX;
                        r_cnt   <= TURN_RX_LOAD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                TURN_RX: begin
                    if (w_phase_done) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Registered outputs decoded from the current state, so the pads see
    // each phase one cycle after the state enters it. tx_ready drops on the
    // accepting edge itself so a held tx_valid is never taken twice.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_pad_i    <= '0;
            r_pad_oen  <= '1;
        end else begin
            r_tx_ready <= (r_state == IDLE) && !w_accept;
            r_busy     <= (r_state != IDLE);
            r_pad_oen  <= {WIDTH{r_state != DRIVE}};
            r_pad_i    <= (r_state == TURN_TX || r_state == DRIVE) ? r_data : '0;
        end
    end

    // Receive change detection only while idle; the baseline is refreshed at
    // the end of TURN_RX so the echo of our own transmit is not reported.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_baseline <= '0;
        end else begin
            r_rx_valid <= 1'b0;
            if (r_state == IDLE && w_sync != r_baseline) begin
                r_rx_valid <= 1'b1;
                r_rx_data  <= w_sync;
                r_baseline <= w_sync;
            end else if (r_state == TURN_RX && w_phase_done) begin
                r_baseline <= w_sync;
            end
        end
    end

`ifdef PADBID_LOOPBACK_CHK_EN
    if (HOLD_CYCLES <= SYNC_STAGES) begin : g_bad_loopback
        $error("padbid_dir_ctrl: loopback check needs HOLD_CYCLES > SYNC_STAGES");
    end

    logic r_last_drive;
    logic r_lb_err;

    // r_last_drive marks the last cycle the pads are actually driven (one
    // cycle after the last DRIVE state cycle); by then the synchroniser
    // output already carries a value sampled inside the drive window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_drive <= 1'b0;
            r_lb_err     <= 1'b0;
        end else begin
            r_last_drive <= (r_state == DRIVE) && w_phase_done;
            if (bus.lb_err_clr) begin
                r_lb_err <= 1'b0;
            end else if (r_last_drive && (w_sync != r_data)) begin
                r_lb_err <= 1'b1;
            end
        end
    end

    assign bus.lb_err = r_lb_err;
`else
    logic w_unused_lb_err_clr;
    assign w_unused_lb_err_clr = bus.lb_err_clr;
    assign bus.lb_err          = 1'b0;
`endif

    assign bus.tx_ready = r_tx_ready;
    assign bus.busy     = r_busy;
    assign bus.pad_i    = r_pad_i;
    assign bus.pad_oen  = r_pad_oen;
    assign bus.rx_valid = r_rx_valid;
    assign bus.rx_data  = r_rx_data;

endmodule

// File: tb/tb_padbid_dir_ctrl.sv
// -----------------------------------------------------------------------------
// tb_padbid_dir_ctrl
// Self-checking bench for padbid_dir_ctrl with default parameters. A
// timeline model derives every expected output from the accept edge of the
// current transmit and a delayed copy of the pad inputs. Pads echo pad_i
// while OEN is low, otherwise show pad_ext (or 0 when lb_stuck is set).
// -----------------------------------------------------------------------------
module tb_padbid_dir_ctrl;

    localparam int W = 5;
    localparam int T = 2;
    localparam int H = 3;
    localparam int S = 2;
    localparam int L = T + H + T + S;   // cycles from accept edge until IDLE

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    padbid_dir_ctrl_if #(.WIDTH(W)) bus ();

    padbid_dir_ctrl #(
        .WIDTH       (W),
        .TURN_CYCLES (T),
        .HOLD_CYCLES (H),
        .SYNC_STAGES (S)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] pad_ext;
    logic         lb_stuck;

    logic         exp_ready, exp_busy, exp_rxv, exp_lb;
    logic [W-1:0] exp_pad_i, exp_oen, exp_rxd;

    assign bus.pad_c = lb_stuck ? '0 : ((exp_oen == '0) ? exp_pad_i : pad_ext);

    // ------------------------------------------------------------------
    // Reference model: expected outputs for each cycle from the accept edge
    // acc of the latest transmit and the pad history.
    // ------------------------------------------------------------------
    initial begin : model
        int           acc;
        int           cyc;
        int           prev;
        logic         idle_prev;
        logic [W-1:0] data, base, sync_cur;
        logic         lb;
        logic [W-1:0] q[$];

        acc = -1000; cyc = 0; data = '0; base = '0; sync_cur = '0; lb = 1'b0;
        for (int i = 0; i < S; i++) q.push_back('0);
        exp_ready <= 1'b1; exp_busy <= 1'b0; exp_oen <= '1; exp_pad_i <= '0;
        exp_rxv <= 1'b0; exp_rxd <= '0; exp_lb <= 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                acc = -1000; base = '0; sync_cur = '0; lb = 1'b0;
                q.delete();
                for (int i = 0; i < S; i++) q.push_back('0);
                exp_ready <= 1'b1; exp_busy <= 1'b0; exp_oen <= '1; exp_pad_i <= '0;
                exp_rxv <= 1'b0; exp_rxd <= '0; exp_lb <= 1'b0;
            end else begin
                prev      = cyc - 1;
                idle_prev = (prev < acc) || (prev >= acc + L);
                exp_rxv <= 1'b0;
                if (idle_prev && sync_cur != base) begin
                    exp_rxv <= 1'b1;
                    exp_rxd <= sync_cur;
                    base = sync_cur;
                end else if (prev == acc + L - 1) begin
                    base = sync_cur;
                end
`ifdef PADBID_LOOPBACK_CHK_EN
                if (bus.lb_err_clr) lb = 1'b0;
                else if (prev == acc + T + H && sync_cur != data) lb = 1'b1;
`endif
                if (bus.tx_valid && exp_ready) begin
                    acc  = cyc;
                    data = bus.tx_data;
                end
                q.push_back(bus.pad_c);
                sync_cur = q[1];
                void'(q.pop_front());
                exp_ready <= !(cyc >= acc && cyc <= acc + L);
                exp_busy  <= (cyc >= acc + 1 && cyc <= acc + L);
                exp_pad_i <= (cyc >= acc + 1 && cyc <= acc + T + H) ? data : '0;
                exp_oen   <= (cyc >= acc + T + 1 && cyc <= acc + T + H) ? '0 : '1;
                exp_lb    <= lb;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks += 4;
            if (bus.pad_oen !== 5'h1F) begin n_fail++; $display("FAIL reset_oen: got %h want 1f", bus.pad_oen); end
            if (bus.pad_i !== 5'h00) begin n_fail++; $display("FAIL reset_pad_i: got %h want 00", bus.pad_i); end
            if (bus.tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.tx_ready); end
            if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rxv: got %b want 0", bus.rx_valid); end
        end
        n_checks += 3;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        if (bus.rx_data !== 5'h00) begin n_fail++; $display("FAIL reset_rxd: got %h want 00", bus.rx_data); end
        if (bus.lb_err !== 1'b0) begin n_fail++; $display("FAIL reset_lb: got %b want 0", bus.lb_err); end
    endtask

    task automatic test_tx_timing();
        logic [W-1:0] want_oen, want_i;
        bus.tx_valid = 1'b1;
        bus.tx_data  = 5'h15;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);   // cycle N+k, N = accepting edge
            if (k == 0) bus.tx_valid = 1'b0;
            want_oen = (k >= 3 && k <= 5) ? 5'h00 : 5'h1F;
            want_i   = (k >= 1 && k <= 5) ? 5'h15 : 5'h00;
            n_checks += 3;
            if (bus.pad_oen !== want_oen) begin n_fail++; $display("FAIL tx_oen k=%0d: got %h want %h", k, bus.pad_oen, want_oen); end
            if (bus.pad_i !== want_i) begin n_fail++; $display("FAIL tx_pad_i k=%0d: got %h want %h", k, bus.pad_i, want_i); end
            if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_rxv k=%0d: got %b want 0", k, bus.rx_valid); end
            if (k >= 1) begin
                n_checks += 2;
                if (bus.tx_ready !== (k >= 10)) begin n_fail++; $display("FAIL tx_ready k=%0d: got %b want %b", k, bus.tx_ready, k >= 10); end
                if (bus.busy !== (k <= 9)) begin n_fail++; $display("FAIL tx_busy k=%0d: got %b want %b", k, bus.busy, k <= 9); end
            end
        end
    endtask

    task automatic test_rx_change();
        repeat (3) @(negedge clk);
        pad_ext = 5'h0A;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            n_checks++;
            if (bus.rx_valid !== (j == 3)) begin n_fail++; $display("FAIL rx_pulse j=%0d: got %b want %b", j, bus.rx_valid, j == 3); end
            if (j == 3) begin
                n_checks++;
                if (bus.rx_data !== 5'h0A) begin n_fail++; $display("FAIL rx_data: got %h want 0a", bus.rx_data); end
            end
        end
    endtask

    task automatic test_echo();
        bus.tx_valid = 1'b1;
        bus.tx_data  = 5'h1F;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 0) bus.tx_valid = 1'b0;
            if (k == 4) pad_ext = 5'h1F;   // pad keeper retains the driven value
            n_checks++;
            if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL echo_rxv k=%0d: got %b want 0", k, bus.rx_valid); end
        end
        pad_ext = 5'h00;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            n_checks++;
            if (bus.rx_valid !== (j == 3)) begin n_fail++; $display("FAIL echo_change j=%0d: got %b want %b", j, bus.rx_valid, j == 3); end
            if (j == 3) begin
                n_checks++;
                if (bus.rx_data !== 5'h00) begin n_fail++; $display("FAIL echo_rxd: got %h want 00", bus.rx_data); end
            end
        end
    endtask

    task automatic test_reset_in_drive();
        bus.tx_valid = 1'b1;
        bus.tx_data  = 5'h15;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            if (k == 0) bus.tx_valid = 1'b0;
            if (k == 3) begin
                n_checks++;
                if (bus.pad_oen !== 5'h00) begin n_fail++; $display("FAIL rd_driving: got %h want 00", bus.pad_oen); end
                rst = 1'b1;
                bus.tx_valid = 1'b1;
                bus.tx_data  = 5'h0A;
            end
            if (k == 4) begin
                n_checks += 4;
                if (bus.pad_oen !== 5'h1F) begin n_fail++; $display("FAIL rd_oen: got %h want 1f", bus.pad_oen); end
                if (bus.pad_i !== 5'h00) begin n_fail++; $display("FAIL rd_pad_i: got %h want 00", bus.pad_i); end
                if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rd_busy: got %b want 0", bus.busy); end
                if (bus.tx_ready !== 1'b1) begin n_fail++; $display("FAIL rd_ready: got %b want 1", bus.tx_ready); end
                rst = 1'b0;
            end
            if (k == 5) begin
                n_checks++;
                if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rd_idle: got %b want 0", bus.busy); end
                bus.tx_valid = 1'b0;
            end
            if (k == 6) begin
                n_checks += 3;
                if (bus.pad_i !== 5'h0A) begin n_fail++; $display("FAIL rd_new_i: got %h want 0a", bus.pad_i); end
                if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rd_new_busy: got %b want 1", bus.busy); end
                if (bus.pad_oen !== 5'h1F) begin n_fail++; $display("FAIL rd_new_turn: got %h want 1f", bus.pad_oen); end
            end
            if (k == 8) begin
                n_checks++;
                if (bus.pad_oen !== 5'h00) begin n_fail++; $display("FAIL rd_new_oen: got %h want 00", bus.pad_oen); end
            end
            if (k == 15) begin
                n_checks++;
                if (bus.tx_ready !== 1'b1) begin n_fail++; $display("FAIL rd_new_ready: got %b want 1", bus.tx_ready); end
            end
        end
    endtask

    task automatic test_random();
        logic ready_last;
        ready_last = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!rst) begin
                n_checks += 7;
                if (bus.tx_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, bus.tx_ready, exp_ready); end
                if (bus.busy !== exp_busy) begin n_fail++; $display("FAIL rnd_busy c=%0d: got %b want %b", c, bus.busy, exp_busy); end
                if (bus.pad_i !== exp_pad_i) begin n_fail++; $display("FAIL rnd_pad_i c=%0d: got %h want %h", c, bus.pad_i, exp_pad_i); end
                if (bus.pad_oen !== exp_oen) begin n_fail++; $display("FAIL rnd_oen c=%0d: got %h want %h", c, bus.pad_oen, exp_oen); end
                if (bus.rx_valid !== exp_rxv) begin n_fail++; $display("FAIL rnd_rxv c=%0d: got %b want %b", c, bus.rx_valid, exp_rxv); end
                if (bus.rx_data !== exp_rxd) begin n_fail++; $display("FAIL rnd_rxd c=%0d: got %h want %h", c, bus.rx_data, exp_rxd); end
                if (bus.lb_err !== exp_lb) begin n_fail++; $display("FAIL rnd_lb c=%0d: got %b want %b", c, bus.lb_err, exp_lb); end
            end
            if (bus.tx_valid && ready_last) bus.tx_valid = 1'b0;
            else if (!bus.tx_valid && $urandom_range(0, 3) == 0) begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = W'($urandom);
            end
            if ($urandom_range(0, 7) == 0) pad_ext = W'($urandom);
            bus.lb_err_clr = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 99) == 0);
            ready_last = exp_ready;
        end
        rst = 1'b0;
        bus.tx_valid   = 1'b0;
        bus.lb_err_clr = 1'b0;
        pad_ext        = 5'h00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_loopback();
        logic want;
        lb_stuck     = 1'b1;
        bus.tx_valid = 1'b1;
        bus.tx_data  = 5'h01;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) bus.tx_valid = 1'b0;
`ifdef PADBID_LOOPBACK_CHK_EN
            want = (k >= 6);
`else
            want = 1'b0;
`endif
            n_checks++;
            if (bus.lb_err !== want) begin n_fail++; $display("FAIL lb_set k=%0d: got %b want %b", k, bus.lb_err, want); end
        end
        bus.lb_err_clr = 1'b1;
        @(negedge clk);
        bus.lb_err_clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.lb_err !== 1'b0) begin n_fail++; $display("FAIL lb_clr k=%0d: got %b want 0", k, bus.lb_err); end
        end
        lb_stuck = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.tx_valid   = 1'b0;
        bus.tx_data    = '0;
        bus.lb_err_clr = 1'b0;
        pad_ext        = '0;
        lb_stuck       = 1'b0;
        test_reset();
        test_tx_timing();
        test_rx_change();
        test_echo();
        test_reset_in_drive();
        test_random();
        test_loopback();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
